bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: requester, shared-bus and pipeline-control signals of the fetch/data bus arbiter.
interface bus_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        flush;
    logic        stallreq_if;
    logic        stallreq_mem;
    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, bus_rdata, bus_ack, flush,
        output if_rdata, if_ack, mem_rdata, mem_ack, bus_stb, bus_we, bus_addr, bus_sel, bus_wdata,
               stallreq_if, stallreq_mem
    );
    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_sel, mem_wdata, bus_rdata, bus_ack, flush,
        input  if_rdata, if_ack, mem_rdata, mem_ack, bus_stb, bus_we, bus_addr, bus_sel, bus_wdata,
               stallreq_if, stallreq_mem
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one bus between instruction fetch and data access, MEM-first with IF anti-starvation.
module bus_arbiter (
    input logic clk,
    input logic rst,
    bus_arbiter_if.master b
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
    state_t state, state_n;
    logic [2:0] starve_cnt, starve_n;
    logic flushed, grant_if, grant_mem, done, deliver;
    assign b.stallreq_if  = b.if_req & ~b.if_ack;
    assign b.stallreq_mem = b.mem_req & ~b.mem_ack;
    // no grant while an ack pulse is out: the requester still holds req during that cycle
    always_comb begin
        state_n   = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!b.flush && !b.if_ack && !b.mem_ack) begin
                    grant_if  = b.if_req && (!b.mem_req || starve_cnt == 3'd4);
                    grant_mem = b.mem_req && !grant_if;
                    state_n   = grant_if ? IF_BUSY : grant_mem ? MEM_BUSY : IDLE;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                done    = b.bus_ack;
                state_n = b.bus_ack ? IDLE : state;
            end
            default: state_n = IDLE;
        endcase
        deliver  = done && !flushed && !b.flush;
        starve_n = (grant_if || !b.if_req) ? 3'd0 : (starve_cnt == 3'd4) ? 3'd4 : starve_cnt + 3'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt  <= 3'd0;
            flushed     <= 1'b0;
            b.bus_stb   <= 1'b0;
            b.bus_we    <= 1'b0;
            b.bus_sel   <= 4'h0;
            b.bus_addr  <= 32'h0;
            b.bus_wdata <= 32'h0;
            b.if_rdata  <= 32'h0;
            b.mem_rdata <= 32'h0;
            b.if_ack    <= 1'b0;
            b.mem_ack   <= 1'b0;
        end else begin
            b.if_ack  <= deliver && state == IF_BUSY;
            b.mem_ack <= deliver && state == MEM_BUSY;
            if (deliver && state == IF_BUSY) b.if_rdata <= b.bus_rdata;
            if (deliver && state == MEM_BUSY && !b.bus_we) b.mem_rdata <= b.bus_rdata;
            // a flush seen anywhere in the transaction cancels its completion
            flushed <= state != IDLE && !done && (flushed || b.flush);
            if (grant_if || grant_mem) begin
                b.bus_stb   <= 1'b1;
                b.bus_we    <= grant_mem && b.mem_we;
                b.bus_sel   <= grant_if ? 4'hf : b.mem_sel;
                b.bus_addr  <= grant_if ? b.if_addr : b.mem_addr;
                b.bus_wdata <= grant_if ? 32'h0 : b.mem_wdata;
                starve_cnt  <= starve_n;
            end else if (done) begin
                b.bus_stb <= 1'b0;
            end
        end
    end
endmodule
